calculate_new_capacity: RTL and testbench
=========================================

// Module: calculate_new_capacity
// PURPOSE
//   Parking-occupancy updater for the smart-parking controller. Takes the current
//   occupancy bitmap and a one-hot request for the spot being taken, and returns
//   the updated bitmap.
//   Also reports free-spot count, full status and request errors.
//   The result is registered with one cycle of latency.
// PARAMETERS
//   N_SPOTS  8  number of parking spots; sets the width of every bitmap
//   CNT_W    $clog2(N_SPOTS+1)=4  width of free_count
// PORTS
//   clk               in   1        single clock; all state updates on rising edge
//   rst_n             in   1        synchronous, active-low reset
//   in_valid          in   1        request qualifier; inputs are sampled when high
//   park_location     in   N_SPOTS  one-hot spot being taken (bit i = spot i)
//   parking_capacity  in   N_SPOTS  current occupancy map (1 = occupied)
//   out_valid         out  1        result valid; high for exactly 1 cycle per request
//   new_capacity      out  N_SPOTS  updated occupancy map
//   free_count        out  CNT_W    number of zero bits in new_capacity
//   full              out  1        new_capacity is all ones
//   err_onehot        out  1        park_location was zero or had more than one bit set
//   err_occupied      out  1        requested spot was already occupied
// BEHAVIOUR
//   - Reset (rst_n=0 at a rising edge) has priority over any request and sets:
//     out_valid=0, new_capacity=0, free_count=N_SPOTS, full=0, both err flags=0.
//   - Request with in_valid=1 at edge k: the results below are registered at edge k,
//     and out_valid=1 during cycle k+1. Latency is 1 cycle and throughput is 1 request
//     per cycle. There is no backpressure.
//   - Valid one-hot location on a free spot: new_capacity = parking_capacity | park_location.
//   - Location not one-hot (zero or multi-hot): err_onehot=1 and new_capacity = parking_capacity.
//   - One-hot location on an occupied spot: err_occupied=1 and new_capacity = parking_capacity.
//   - err_onehot is checked before err_occupied, so at most one error flag is set.
//   - free_count and full are always derived from the registered new_capacity.
//   - in_valid=0: out_valid=0, and all data outputs and flags hold their previous values.
//   - A request when full=1 (capacity 0xFF) can only produce err_occupied or err_onehot.
//   - The block is purely combinational from its inputs to its registers. It keeps no
//     internal occupancy state; the caller feeds back new_capacity.
// CONFIGURATION
//   RELEASE_EN defined:
//     - Adds input `release` (1 bit, sampled with in_valid).
//     - release=1 clears the spot: new_capacity = parking_capacity & ~park_location.
//     - Releasing a spot that is already free sets err_occupied (reused to mean
//       "state mismatch") and leaves the map unchanged.
//     - err_onehot rules are the same as for a park request.
//   RELEASE_EN undefined: there is no release port, and every request is a park request.
// STRUCTURE
//   - Package calc_cap_pkg holds:
//     - N_SPOTS and CNT_W as localparams;
//     - typedef logic [N_SPOTS-1:0] spot_map_t;
//     - typedef logic [CNT_W-1:0] spot_cnt_t.
//   - Sub-module spot_popcount is combinational: input spot_map_t, output spot_cnt_t
//     count of ones. Here free_count = N_SPOTS - popcount.
//   - The one-hot check is inline: (loc != 0) && ((loc & (loc-1)) == 0).
// TESTING
//   - Basic park: loc=0x02, cap=0x44, in_valid=1 -> next cycle new_capacity=0x46,
//     free_count=5, full=0, no errors.
//   - Occupied: loc=0x04, cap=0x44 -> new_capacity=0x44, err_occupied=1, free_count=6.
//   - Bad location:
//     - loc=0x03, cap=0x10 -> new_capacity=0x10, err_onehot=1, err_occupied=0.
//     - loc=0x00 gives the same result.
//   - Fill last spot: loc=0x80, cap=0x7F -> new_capacity=0xFF, full=1, free_count=0.
//   - Reset: assert rst_n=0 together with in_valid=1 -> next cycle out_valid=0,
//     new_capacity=0, free_count=8. Back-to-back requests give out_valid=1 in each cycle.
//   - RELEASE_EN:
//     - release=1, loc=0x04, cap=0x44 -> new_capacity=0x40.
//     - release=1, loc=0x01, cap=0x44 -> err_occupied=1.

Source files
------------

// File: rtl/calculate_new_capacity_pkg.sv
// Shared sizes and types for the parking-occupancy updater.
package calc_cap_pkg;

  localparam int unsigned N_SPOTS = 8;
  localparam int unsigned CNT_W   = $clog2(N_SPOTS + 1);

  typedef logic [N_SPOTS-1:0] spot_map_t;
  typedef logic [CNT_W-1:0]   spot_cnt_t;

endpackage

// File: rtl/calculate_new_capacity_spot_popcount.sv
// Combinational count of set bits in a spot map.
module spot_popcount
  import calc_cap_pkg::*;
(
  input  spot_map_t map,
  output spot_cnt_t count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < N_SPOTS; i++) begin
      count_c = count_c + CNT_W'(map[i]);
    end
  end

endmodule

// File: rtl/calculate_new_capacity.sv
// Parking-occupancy updater: applies a one-hot park (or release) request to the
// supplied map and registers the result, free count, full and error flags.
// Optional RELEASE_EN adds the release_spot input ("release" is a reserved word).
module calculate_new_capacity
  import calc_cap_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
`ifdef RELEASE_EN
  input  logic      release_spot,
`endif
  input  spot_map_t park_location,
  input  spot_map_t parking_capacity,
  output logic      out_valid,
  output spot_map_t new_capacity,
  output spot_cnt_t free_count,
  output logic      full,
  output logic      err_onehot,
  output logic      err_occupied
);

  logic      loc_onehot;
  spot_map_t nxt_cap;
  logic      nxt_err_onehot;
  logic      nxt_err_occupied;
  spot_cnt_t nxt_used;

  assign loc_onehot = (park_location != '0) &&
                      ((park_location & (park_location - spot_map_t'(1))) == '0);

  // Next map and error flags; onehot error takes precedence over occupancy error.
  always_comb begin
    nxt_cap          = parking_capacity;
    nxt_err_onehot   = 1'b0;
    nxt_err_occupied = 1'b0;
    if (!loc_onehot) begin
      nxt_err_onehot = 1'b1;
    end
`ifdef RELEASE_EN
    else if (release_spot) begin
      if ((parking_capacity & park_location) == '0) nxt_err_occupied = 1'b1;
      else nxt_cap = parking_capacity & ~park_location;
    end
`endif
    else if ((parking_capacity & park_location) != '0) begin
      nxt_err_occupied = 1'b1;
    end else begin
      nxt_cap = parking_capacity | park_location;
    end
  end

  spot_popcount u_popcount (
    .map     (nxt_cap),
    .count_c (nxt_used)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      new_capacity <= '0;
      free_count   <= CNT_W'(N_SPOTS);
      full         <= 1'b0;
      err_onehot   <= 1'b0;
      err_occupied <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        new_capacity <= nxt_cap;
        free_count   <= CNT_W'(N_SPOTS) - nxt_used;
        full         <= (nxt_cap == '1);
        err_onehot   <= nxt_err_onehot;
        err_occupied <= nxt_err_occupied;
      end
    end
  end

endmodule

// File: tb/tb_calculate_new_capacity.sv
// Directed self-checking bench for calculate_new_capacity (RELEASE_EN aware).
module tb_calculate_new_capacity;
  import calc_cap_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      in_valid;
  logic      release_spot;
  spot_map_t park_location;
  spot_map_t parking_capacity;
  logic      out_valid;
  spot_map_t new_capacity;
  spot_cnt_t free_count;
  logic      full;
  logic      err_onehot;
  logic      err_occupied;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  calculate_new_capacity dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
`ifdef RELEASE_EN
    .release_spot     (release_spot),
`endif
    .park_location    (park_location),
    .parking_capacity (parking_capacity),
    .out_valid        (out_valid),
    .new_capacity     (new_capacity),
    .free_count       (free_count),
    .full             (full),
    .err_onehot       (err_onehot),
    .err_occupied     (err_occupied)
  );

  // Present one cycle of inputs and sample the outputs 1 time unit after the edge.
  task automatic drive(input logic v, input logic rel, input spot_map_t loc, input spot_map_t cap);
    in_valid         = v;
    release_spot     = rel;
    park_location    = loc;
    parking_capacity = cap;
    @(posedge clk);
    #1;
  endtask

  // Compare the full output vector against an expected one.
  task automatic expect_all(input string name, input logic ov, input spot_map_t cap,
                            input spot_cnt_t fc, input logic fl, input logic eoh, input logic eocc);
    nvec++;
    if ({out_valid, new_capacity, free_count, full, err_onehot, err_occupied} !==
        {ov, cap, fc, fl, eoh, eocc}) begin
      nerr++;
      $display("FAIL %s: got ov=%b cap=%h fc=%0d full=%b eoh=%b eocc=%b, want ov=%b cap=%h fc=%0d full=%b eoh=%b eocc=%b",
               name, out_valid, new_capacity, free_count, full, err_onehot, err_occupied,
               ov, cap, fc, fl, eoh, eocc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h02, 8'h44);
    drive(1'b1, 1'b0, 8'h02, 8'h44);
    expect_all("reset", 1'b0, 8'h00, 4'd8, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_park();
    drive(1'b1, 1'b0, 8'h02, 8'h44);
    expect_all("park_basic", 1'b1, 8'h46, 4'd5, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h01, 8'h00);
    expect_all("park_empty", 1'b1, 8'h01, 4'd7, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_occupied();
    drive(1'b1, 1'b0, 8'h04, 8'h44);
    expect_all("occupied", 1'b1, 8'h44, 4'd6, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_bad_location();
    drive(1'b1, 1'b0, 8'h03, 8'h10);
    expect_all("multi_hot", 1'b1, 8'h10, 4'd7, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h10);
    expect_all("zero_loc", 1'b1, 8'h10, 4'd7, 1'b0, 1'b1, 1'b0);
    // Multi-hot overlapping an occupied spot still reports only the onehot error.
    drive(1'b1, 1'b0, 8'h30, 8'h10);
    expect_all("multi_hot_occ", 1'b1, 8'h10, 4'd7, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_full();
    drive(1'b1, 1'b0, 8'h80, 8'h7F);
    expect_all("fill_last", 1'b1, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h01, 8'hFF);
    expect_all("full_occ", 1'b1, 8'hFF, 4'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'hFF, 8'hFF);
    expect_all("full_bad", 1'b1, 8'hFF, 4'd0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 8'h08, 8'h01);
    expect_all("hold_setup", 1'b1, 8'h09, 4'd6, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h03, 8'hFF);
    expect_all("hold_idle1", 1'b0, 8'h09, 4'd6, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    expect_all("hold_idle2", 1'b0, 8'h09, 4'd6, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 8'h01, 8'h00);
    expect_all("b2b_0", 1'b1, 8'h01, 4'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h20, 8'h01);
    expect_all("b2b_1", 1'b1, 8'h21, 4'd6, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h20, 8'h21);
    expect_all("b2b_2", 1'b1, 8'h21, 4'd6, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h40, 8'h21);
    expect_all("b2b_3", 1'b1, 8'h61, 4'd5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_priority();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h80, 8'h7F);
    expect_all("reset_prio", 1'b0, 8'h00, 4'd8, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h10, 8'h0F);
    expect_all("post_reset", 1'b1, 8'h1F, 4'd3, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef RELEASE_EN
  task automatic test_release();
    drive(1'b1, 1'b1, 8'h04, 8'h44);
    expect_all("release_ok", 1'b1, 8'h40, 4'd7, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'h01, 8'h44);
    expect_all("release_free", 1'b1, 8'h44, 4'd6, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h05, 8'h44);
    expect_all("release_bad", 1'b1, 8'h44, 4'd6, 1'b0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    rst_n            = 1'b1;
    in_valid         = 1'b0;
    release_spot     = 1'b0;
    park_location    = '0;
    parking_capacity = '0;
    test_reset();
    test_park();
    test_occupied();
    test_bad_location();
    test_full();
    test_hold();
    test_back_to_back();
    test_reset_priority();
`ifdef RELEASE_EN
    test_release();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
